// File: rtl/hotkey_ctrl_if.sv
// hotkey_ctrl_if: groups the hotkey controller's per-cycle inputs (clock enable,
// raw key levels, user reset request) and its outputs (modes, press pulses,
// power-good, gated system reset). The master drives the inputs; the slave is
// the controller itself.
interface hotkey_ctrl_if #(
  parameter int KEYS      = 4,
  parameter int MODE_BITS = 2
);
  logic                      ce;
  logic [KEYS-1:0]           key;
  logic                      rstIn;
  logic [KEYS*MODE_BITS-1:0] mode;
  logic [KEYS-1:0]           press;
  logic                      power;
  logic                      rstOut;

  modport master (
    output ce, key, rstIn,
    input  mode, press, power, rstOut
  );

  modport slave (
    input  ce, key, rstIn,
    output mode, press, power, rstOut
  );
endinterface

// File: rtl/hotkey_ctrl.sv
// hotkey_ctrl: debounces KEYS active-low hotkey lines, advances a wrapping mode
// counter per key on every debounced press, runs the power-on counter and
// produces the registered active-low system reset (power & rstIn).
// Optional feature macro: HOTKEY_LONGPRESS_EN -- adds a per-key hold counter;
// holding a key until it saturates clears that key's mode and pulses press once.
module hotkey_ctrl #(
  parameter int              KEYS      = 4,
  parameter int              MODE_BITS = 2,
  parameter int              MODES     = 2,
  parameter int              DB_BITS   = 2,
  parameter int              PW_BITS   = 4,
  parameter logic [KEYS-1:0] PWR_MASK  = 4'b0011
) (
  input  logic         clock,
  input  logic         reset,
  hotkey_ctrl_if.slave bus
);

  localparam logic [DB_BITS-1:0]   DB_MAX    = {DB_BITS{1'b1}};
  localparam logic [MODE_BITS-1:0] MODE_LAST = MODE_BITS'(MODES - 1);

  // fall[k]: this edge moves key k's debounced level from released to held
  logic [KEYS-1:0]    fall;
  logic [PW_BITS-1:0] pw_reg;
  logic               pw_clear;
  logic               rstout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < KEYS; gi = gi + 1) begin : g_key
      logic                 stable_reg;
      logic [DB_BITS-1:0]   db_cnt_reg;
      logic [MODE_BITS-1:0] mode_reg;
      logic                 press_reg;
      logic                 flip;
      logic                 long_hit;

      // The debounced level changes only after 2^DB_BITS consecutive ce ticks of disagreement.
      assign flip     = bus.ce && (bus.key[gi] != stable_reg) && (db_cnt_reg == DB_MAX);
      assign fall[gi] = flip && stable_reg;

      // Debounce: count consecutive ce ticks where the raw level differs from the stable one.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          stable_reg <= 1'b1;
          db_cnt_reg <= '0;
        end else if (bus.ce) begin
          if (bus.key[gi] == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg != DB_MAX) begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end else begin
            stable_reg <= bus.key[gi];
            db_cnt_reg <= '0;
          end
        end
      end

`ifdef HOTKEY_LONGPRESS_EN
      localparam int                   HOLD_BITS = DB_BITS + 4;
      localparam logic [HOLD_BITS-1:0] HOLD_MAX  = {HOLD_BITS{1'b1}};
      localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_MAX - 1'b1;

      logic [HOLD_BITS-1:0] hold_cnt_reg;
      logic                 rise;

      // A release on the saturating tick must not count as a completed long hold.
      assign rise     = flip && !stable_reg;
      assign long_hit = bus.ce && !stable_reg && !rise && (hold_cnt_reg == HOLD_LAST);

      // Hold counter: ce ticks spent debounced-held; clears on release, sticks at all-ones.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hold_cnt_reg <= '0;
        end else if (bus.ce) begin
          if (stable_reg) begin
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
      end
`else
      assign long_hit = 1'b0;
`endif

      // Mode counter and press pulse; the pulse self-clears on the next edge even with ce low.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          mode_reg  <= '0;
          press_reg <= 1'b0;
        end else begin
          press_reg <= fall[gi] | long_hit;
          if (fall[gi]) begin
            mode_reg <= (mode_reg == MODE_LAST) ? '0 : mode_reg + 1'b1;
          end else if (long_hit) begin
            mode_reg <= '0;
          end
        end
      end

      assign bus.mode[gi*MODE_BITS +: MODE_BITS] = mode_reg;
      assign bus.press[gi]                       = press_reg;
    end
  endgenerate

  // Any debounced press on a power-sensitive key restarts the power-on sequence.
  assign pw_clear = |(fall & PWR_MASK);

  // Power-on counter: runs until its MSB sets, then holds; a restart has priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pw_reg <= '0;
    end else if (bus.ce) begin
      if (pw_clear) begin
        pw_reg <= '0;
      end else if (!pw_reg[PW_BITS-1]) begin
        pw_reg <= pw_reg + 1'b1;
      end
    end
  end

  // System reset output follows power & rstIn one clock later, independent of ce.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstout_reg <= 1'b0;
    end else begin
      rstout_reg <= pw_reg[PW_BITS-1] & bus.rstIn;
    end
  end

  assign bus.power  = pw_reg[PW_BITS-1];
  assign bus.rstOut = rstout_reg;

endmodule

// File: tb/tb_hotkey_ctrl.sv
// tb_hotkey_ctrl: scoreboard bench. The stimulus process drives inputs shortly
// after each falling edge and runs a reference model that predicts what the next
// rising edge produces (press pulses with modes, power and rstOut changes),
// pushing expectations tagged with that edge number. A monitor at each falling
// edge pops and compares, and checks that nothing changes without an expectation.
`timescale 1ns/1ps
module tb_hotkey_ctrl;
  localparam int              KEYS      = 4;
  localparam int              MODE_BITS = 2;
  localparam int              MODES     = 3;
  localparam int              DB_BITS   = 2;
  localparam int              PW_BITS   = 4;
  localparam logic [KEYS-1:0] PWR_MASK  = 4'b0011;
  localparam int              DB_TICKS  = 1 << DB_BITS;
  localparam int              PW_TICKS  = 1 << (PW_BITS - 1);
`ifdef HOTKEY_LONGPRESS_EN
  localparam int              HOLD_SAT  = (1 << (DB_BITS + 4)) - 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  hotkey_ctrl_if #(.KEYS(KEYS), .MODE_BITS(MODE_BITS)) bus ();

  hotkey_ctrl #(
    .KEYS(KEYS), .MODE_BITS(MODE_BITS), .MODES(MODES),
    .DB_BITS(DB_BITS), .PW_BITS(PW_BITS), .PWR_MASK(PWR_MASK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, act, exp);
    end
  endfunction

  typedef struct {
    int                        cyc;
    logic [KEYS-1:0]           mask;
    logic [KEYS*MODE_BITS-1:0] mode;
  } press_t;

  typedef struct {
    int   cyc;
    logic val;
  } lvl_t;

  press_t press_q[$];
  lvl_t   power_q[$];
  lvl_t   rstout_q[$];

  // Reference model: a key's debounced level follows the raw level once the
  // last DB_TICKS ce samples all disagree with it; power is "enough ce ticks
  // since the last restart".
  logic [DB_TICKS-1:0] m_hist   [KEYS];
  logic                m_stable [KEYS];
  int                  m_mode   [KEYS];
  int                  m_hold   [KEYS];
  int                  m_ticks;
  logic                m_power;
  logic                m_rstout;

  function automatic void model_reset();
    for (int i = 0; i < KEYS; i++) begin
      m_hist[i]   = '1;
      m_stable[i] = 1'b1;
      m_mode[i]   = 0;
      m_hold[i]   = 0;
    end
    m_ticks  = 0;
    m_power  = 1'b0;
    m_rstout = 1'b0;
    press_q.delete();
    power_q.delete();
    rstout_q.delete();
  endfunction

  function automatic void model_edge(input logic c, input logic [KEYS-1:0] k, input logic r);
    logic [KEYS-1:0]           pmask;
    logic [KEYS-1:0]           lmask;
    logic [KEYS*MODE_BITS-1:0] mv;
    logic                      new_rst;
    logic                      new_pwr;
    logic                      was_low;
    logic                      released;
    int                        nxt;
    nxt     = edge_n + 1;
    pmask   = '0;
    lmask   = '0;
    new_rst = m_power & r;
    if (c) begin
      for (int i = 0; i < KEYS; i++) begin
        was_low   = !m_stable[i];
        released  = 1'b0;
        m_hist[i] = {m_hist[i][DB_TICKS-2:0], k[i]};
        if (m_hist[i] == {DB_TICKS{~m_stable[i]}}) begin
          m_stable[i] = k[i];
          if (!k[i]) begin
            pmask[i]  = 1'b1;
            m_mode[i] = (m_mode[i] + 1) % MODES;
          end else begin
            released = 1'b1;
          end
        end
`ifdef HOTKEY_LONGPRESS_EN
        if (!was_low) begin
          m_hold[i] = 0;
        end else if (m_hold[i] < HOLD_SAT) begin
          m_hold[i]++;
          if (m_hold[i] == HOLD_SAT && !released) begin
            lmask[i]  = 1'b1;
            m_mode[i] = 0;
          end
        end
`else
        if (was_low && released) m_hold[i] = 0;
`endif
      end
      if ((pmask & PWR_MASK) != '0) m_ticks = 0;
      else if (m_ticks < PW_TICKS) m_ticks++;
    end
    new_pwr = (m_ticks >= PW_TICKS);
    for (int i = 0; i < KEYS; i++) mv[i*MODE_BITS +: MODE_BITS] = MODE_BITS'(m_mode[i]);
    if ((pmask | lmask) != '0) press_q.push_back('{nxt, pmask | lmask, mv});
    if (new_pwr != m_power) power_q.push_back('{nxt, new_pwr});
    if (new_rst != m_rstout) rstout_q.push_back('{nxt, new_rst});
    m_power  = new_pwr;
    m_rstout = new_rst;
  endfunction

  // Monitor: compare DUT outputs after each rising edge against the scoreboard.
  logic [KEYS*MODE_BITS-1:0] prev_mode;
  logic                      prev_power;
  logic                      prev_rstout;
  always @(negedge clock) begin
    press_t pe;
    lvl_t   le;
    if (!reset) begin
      prev_mode   = bus.mode;
      prev_power  = bus.power;
      prev_rstout = bus.rstOut;
    end else begin
      if (press_q.size() > 0 && press_q[0].cyc == edge_n) begin
        pe = press_q.pop_front();
        check("press_mask", 32'(bus.press), 32'(pe.mask));
        check("press_mode", 32'(bus.mode), 32'(pe.mode));
      end else begin
        check("no_press", 32'(bus.press), 32'd0);
        check("mode_hold", 32'(bus.mode), 32'(prev_mode));
      end
      if (power_q.size() > 0 && power_q[0].cyc == edge_n) begin
        le = power_q.pop_front();
        check("power_edge", 32'(bus.power), 32'(le.val));
      end else begin
        check("power_hold", 32'(bus.power), 32'(prev_power));
      end
      if (rstout_q.size() > 0 && rstout_q[0].cyc == edge_n) begin
        le = rstout_q.pop_front();
        check("rstout_edge", 32'(bus.rstOut), 32'(le.val));
      end else begin
        check("rstout_hold", 32'(bus.rstOut), 32'(prev_rstout));
      end
      prev_mode   = bus.mode;
      prev_power  = bus.power;
      prev_rstout = bus.rstOut;
    end
  end

  task automatic step(input logic c, input logic [KEYS-1:0] k, input logic r);
    @(negedge clock);
    #1;
    bus.ce    = c;
    bus.key   = k;
    bus.rstIn = r;
    model_edge(c, k, r);
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clock);
    #1;
    reset     = 1'b0;
    bus.ce    = 1'b1;
    bus.key   = '1;
    bus.rstIn = 1'b1;
    model_reset();
    #1;
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_press", 32'(bus.press), 32'd0);
    check("rst_power", 32'(bus.power), 32'd0);
    check("rst_rstout", 32'(bus.rstOut), 32'd0);
    repeat (hold) @(negedge clock);
    #1;
    reset = 1'b1;
    model_edge(bus.ce, bus.key, bus.rstIn);
  endtask

  logic [KEYS-1:0] key_r;
  int              idx;

  initial begin
    bus.ce    = 1'b0;
    bus.key   = '1;
    bus.rstIn = 1'b1;
    #1 reset  = 1'b0;
    apply_reset(3);

    // Power-up with all keys released.
    repeat (12) step(1'b1, 4'hF, 1'b1);
    // key[2]: 4-tick press, then a 3-tick glitch.
    repeat (4) step(1'b1, 4'hB, 1'b1);
    repeat (6) step(1'b1, 4'hF, 1'b1);
    repeat (3) step(1'b1, 4'hB, 1'b1);
    repeat (6) step(1'b1, 4'hF, 1'b1);
    // Three presses of key[3] wrap its mode.
    for (int n = 0; n < 3; n++) begin
      repeat (5) step(1'b1, 4'h7, 1'b1);
      repeat (5) step(1'b1, 4'hF, 1'b1);
    end
    // key[0] restarts power; then key[0]+key[1] together.
    repeat (5) step(1'b1, 4'hE, 1'b1);
    repeat (14) step(1'b1, 4'hF, 1'b1);
    repeat (5) step(1'b1, 4'hC, 1'b1);
    repeat (14) step(1'b1, 4'hF, 1'b1);
    // User reset request.
    repeat (3) step(1'b1, 4'hF, 1'b0);
    repeat (3) step(1'b1, 4'hF, 1'b1);
    // Sparse clock enable with key[1] held, including rstIn changes while ce is low.
    for (int n = 0; n < 24; n++) step(n % 4 == 3, 4'hD, n != 9);
    for (int n = 0; n < 24; n++) step(n % 4 == 3, 4'hF, 1'b1);
    // Reset asserted mid-debounce.
    repeat (2) step(1'b1, 4'h7, 1'b1);
    apply_reset(2);
    repeat (12) step(1'b1, 4'hF, 1'b1);
`ifdef HOTKEY_LONGPRESS_EN
    repeat (80) step(1'b1, 4'hB, 1'b1);
    repeat (6) step(1'b1, 4'hF, 1'b1);
`endif
    // Randomised key traffic, clock enable and user reset.
    key_r = '1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx        = int'($urandom_range(0, KEYS - 1));
        key_r[idx] = ~key_r[idx];
      end
      step($urandom_range(0, 3) != 0, key_r, $urandom_range(0, 15) != 0);
    end
    repeat (20) step(1'b1, 4'hF, 1'b1);

    @(negedge clock);
    #2;
    check("press_q_empty", 32'(press_q.size()), 32'd0);
    check("power_q_empty", 32'(power_q.size()), 32'd0);
    check("rstout_q_empty", 32'(rstout_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hotkey_ctrl.md
Name: hotkey_ctrl

Overview:
Parametrised system-control block for the machine tops. Debounces N active-low hotkey lines from the PS/2 controller and advances a per-key mode counter on each press. Also sequences the power-on/restart counter and produces the gated active-low system reset. Replaces the ad-hoc per-key toggle and power-counter logic in each top with one instance feeding the main core's mode inputs (RAM expansion, ROM set, cassette mode, ...).

Parameters:
KEYS, 4, number of hotkey inputs (1..8)
MODE_BITS, 2, width of each per-key mode counter
MODES, 2, mode count per key; counter wraps MODES-1 -> 0 (2..2^MODE_BITS)
DB_BITS, 2, debounce counter width; input must differ from stable level for 2^DB_BITS ce ticks (>=1)
PW_BITS, 4, power-on counter width; power asserts when counter MSB sets
PWR_MASK, 4'b0011, bit k=1: a press of key k restarts the power-on sequence

Ports:
clock  in  1  system clock (24 MHz)
reset  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state advances only when ce=1, except press clearing
key  in  KEYS  raw hotkey levels, active-low (0 = held)
rstIn  in  1  user reset request, active-low (F12 & controller reset)
mode  out  KEYS*MODE_BITS  mode of key k at bits [k*MODE_BITS +: MODE_BITS]
press  out  KEYS  one-clock pulse per debounced press
power  out  1  power-good; high once power-on count completes
rstOut  out  1  active-low system reset = power & rstIn, registered

Behaviour:
- Reset (reset=0, async): mode=0, press=0, power=0, pw counter=0, rstOut=0, stable levels=1 (released), debounce counters=0.
- Debounce per key, on ce: raw==stable -> count<=0. raw!=stable and count<2^DB_BITS-1 -> count++. raw!=stable and count==2^DB_BITS-1 -> stable<=raw, count<=0. Glitches shorter than 2^DB_BITS ce ticks never change stable.
- Press event: clock edge where stable goes 1->0. On that same edge: press[k]<=1; mode[k]<=(mode[k]==MODES-1)?0:mode[k]+1. Release (0->1) changes no outputs.
- press[k] is exactly one clock wide; cleared on the next clock edge regardless of ce.
- Power counter, on ce: if any press event on a key with PWR_MASK bit set -> pw<=0 (takes priority); else if pw MSB==0 -> pw++; else hold. power = pw MSB (registered). From reset release, power rises after 2^(PW_BITS-1) ce ticks.
- rstOut registered each clock: power & rstIn; one-clock latency.
- Simultaneous presses on several keys: all modes advance on the same edge; one pw clear.
- Press while power=0: mode still advances; pw restarts from 0 if masked.
- ce=0: debounce, mode and pw hold; rstOut still tracks power & rstIn.
- Mode counters never exceed MODES-1; MODES=2 behaves as a plain toggle.

Optional Feature:
HOTKEY_LONGPRESS_EN. Defined: each key has a hold counter of DB_BITS+4 bits, counting ce ticks while stable=0. When it saturates, mode[k]<=0 and press[k] pulses one clock, once per hold. The counter clears on release. Undefined: no hold counter, and holding a key has no effect beyond the initial press.

Test Plan:
(Defaults, MODES=3, ce=1 every clock.)
- Release reset, keys=4'hF, rstIn=1 -> power=1 after 8 ce ticks; rstOut=1 one clock later; mode=0, press=0 throughout.
- key[2] low 4 ce ticks -> press[2] single one-clock pulse on 4th tick, mode[2] 0->1. key[2] low only 3 ticks -> no pulse, mode unchanged.
- Three clean presses of key[3] -> mode[3] 1,2,0 (wrap); press[3] pulses 3 times; power unaffected (mask bit 0).
- power=1, press key[0] (mask bit 1) -> power=0 and rstOut=0 within 2 clocks, back high after 8 ce ticks. key[0] and key[1] pressed same tick -> both modes advance, single restart.
- ce=1 every 4th clock, key[1] held -> press edge after 4 ce ticks (16 clocks). Assert reset mid-debounce -> all outputs to reset values immediately, no press on release.
- HOTKEY_LONGPRESS_EN: mode[2]=2, hold key[2] for 4+64 ce ticks -> mode[2]=0 plus second press pulse; continued holding gives no further pulses.
